// File: rtl/mw_pkg.sv
// Shared opcodes, exception codes and the writeback request type for mw_writeback_ctrl.
// wb_req_t is sized for the default 5-bit register address and 32-bit datapath.
package mw_pkg;

  localparam int MW_AW = 5;
  localparam int MW_DW = 32;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_ADD  = 3'd1;
  localparam logic [2:0] EXC_ADDI = 3'd2;
  localparam logic [2:0] EXC_SUB  = 3'd3;
  localparam logic [2:0] EXC_MUL  = 3'd4;
  localparam logic [2:0] EXC_DIV  = 3'd5;

  typedef struct packed {
    logic             we;
    logic [MW_AW-1:0] addr;
    logic [MW_DW-1:0] data;
  } wb_req_t;

  // Only add, sub and addi can raise an overflow; anything else yields EXC_NONE.
  function automatic logic [2:0] ovf_code(input logic [4:0] op, input logic [4:0] alu);
    if (op == OP_ADDI) return EXC_ADDI;
    if (op == OP_R && alu == ALU_ADD) return EXC_ADD;
    if (op == OP_R && alu == ALU_SUB) return EXC_SUB;
    return EXC_NONE;
  endfunction

endpackage

// File: rtl/mw_writeback_ctrl_fifo.sv
// mw_pend_fifo: small synchronous FIFO holding late multdiv results until the RF port is free.
module mw_pend_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mw_writeback_ctrl.sv
// Writeback controller: decodes the retiring MW instruction and merges queued multdiv results
// onto the single RF write port. Define MW_MD_EXC_EN to turn multdiv exceptions into EXC_REG writes.
module mw_writeback_ctrl
  import mw_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int PEND_DEPTH = 2,
  parameter int EXC_REG    = 30,
  parameter int LINK_REG   = 31
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_insn,
  input  logic [DATA_W-1:0]             in_o,
  input  logic [DATA_W-1:0]             in_d,
  input  logic                          in_ovf,
  input  logic                          md_valid,
  output logic                          md_ready,
  input  logic [REG_AW-1:0]             md_rd,
  input  logic [DATA_W-1:0]             md_result,
  input  logic                          md_exc,
  input  logic                          md_is_div,
  output logic                          rf_we,
  output logic [REG_AW-1:0]             rf_addr,
  output logic [DATA_W-1:0]             rf_data,
  output logic [$clog2(PEND_DEPTH):0]   pend_count
);

  localparam int ENT_W = REG_AW + DATA_W;

  logic [4:0]        w_op;
  logic [4:0]        w_alu;
  logic [4:0]        w_rd;
  logic [2:0]        w_code;
  wb_req_t           w_dec;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_mw_wr;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_push_ent;
  logic [ENT_W-1:0]  w_head;
  logic [REG_AW-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [REG_AW-1:0] w_mw_addr;
  logic [DATA_W-1:0] w_mw_data;
  logic              r_we;
  logic [REG_AW-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  assign w_op  = in_insn[31:27];
  assign w_rd  = in_insn[26:22];
  assign w_alu = in_insn[6:2];

  // An overflowing add/sub/addi replaces its normal result with an exception code in EXC_REG.
  always_comb begin
    w_dec  = '0;
    w_code = ovf_code(w_op, w_alu);
    if (in_ovf && (w_code != EXC_NONE)) begin
      w_dec.we   = 1'b1;
      w_dec.addr = MW_AW'(EXC_REG);
      w_dec.data = MW_DW'(w_code);
    end else begin
      case (w_op)
        OP_R, OP_ADDI: begin
          w_dec.we   = 1'b1;
          w_dec.addr = MW_AW'(w_rd);
          w_dec.data = MW_DW'(in_o);
        end
        OP_LW: begin
          w_dec.we   = 1'b1;
          w_dec.addr = MW_AW'(w_rd);
          w_dec.data = MW_DW'(in_d);
        end
        OP_JAL: begin
          w_dec.we   = 1'b1;
          w_dec.addr = MW_AW'(LINK_REG);
          w_dec.data = MW_DW'(in_o);
        end
        OP_SETX: begin
          w_dec.we   = 1'b1;
          w_dec.addr = MW_AW'(EXC_REG);
          w_dec.data = MW_DW'(in_insn[26:0]);
        end
        default: ;
      endcase
    end
  end

`ifdef MW_MD_EXC_EN
  always_comb begin
    w_push_ent = {md_rd, md_result};
    if (md_exc) w_push_ent = {REG_AW'(EXC_REG), md_is_div ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MUL)};
  end
`else
  logic w_unused;
  assign w_unused   = md_exc ^ md_is_div;
  assign w_push_ent = {md_rd, md_result};
`endif

  assign in_ready    = ~w_full;
  assign md_ready    = ~w_full;
  assign w_accept    = in_valid & ~w_full;
  assign w_mw_wr     = w_accept & w_dec.we;
  assign w_push      = md_valid & ~w_full;
  assign w_pop       = ~w_mw_wr & ~w_empty;
  assign w_mw_addr   = REG_AW'(w_dec.addr);
  assign w_mw_data   = DATA_W'(w_dec.data);
  assign w_head_addr = w_head[ENT_W-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];

  mw_pend_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_ent),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pend_count)
  );

  // The MW stage owns the port when it writes; queued multdiv results drain in idle slots.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_mw_wr) begin
      r_we   <= |w_mw_addr;
      r_addr <= w_mw_addr;
      r_data <= w_mw_data;
    end else if (w_pop) begin
      r_we   <= |w_head_addr;
      r_addr <= w_head_addr;
      r_data <= w_head_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign rf_we   = r_we;
  assign rf_addr = r_addr;
  assign rf_data = r_data;

endmodule
